fetch_unit: RTL and testbench

Front-end stage that sits directly upstream of decode. It generates the PC, drives the instruction read port of the dual-port memory (fixed 2-cycle read latency, no stall), and buffers returned instructions in a small queue. It presents them to decode with a valid/ready handshake, and discards wrong-path fetches on a redirect (taken jump or halt flush) from execute.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/fetch_unit_if.sv | 39 +++
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/fetch_unit.sv | 89 ++++++++
 tb/tb_fetch_unit.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, reset PC, memory latency and fetch entry type
package cpu_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 16;
    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;
    localparam int MEM_LAT = 2;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit memory, redirect and decode-side signal bundle
interface fetch_unit_if;
    import cpu_pkg::*;

    logic [ADDR_W-2:0]  mem_raddr;
    logic [INSTR_W-1:0] mem_rdata;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               halt;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;

    modport master (
        output mem_raddr,
        input  mem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        input  halt,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    modport slave (
        input  mem_raddr,
        output mem_rdata,
        output redirect_valid,
        output redirect_pc,
        output halt,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of fetch entries; flush beats push and pop
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  fetch_entry_t           din_i,
    output fetch_entry_t           head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    // Entries are zeroed on reset so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
        end
    end

    a_no_push_on_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && full && !pop_i && !flush_i));

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC generation, fixed-latency fetch tracking and decode queue
// Optional FETCH_BYPASS_EN presents an arriving response to decode when the queue is empty.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter int          MEM_LAT  = cpu_pkg::MEM_LAT
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master fif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [15:0]          pc_q, pc_d;
    logic [MEM_LAT-1:0]   vld_q;
    logic [15:0]          ipc_q [MEM_LAT];
    logic [15:0]          fetch_addr;
    logic                 flush;
    logic                 issue;
    logic                 arrive;
    int                   occupancy;
    cpu_pkg::fetch_entry_t arr_entry;
    cpu_pkg::fetch_entry_t head;
    logic [CW-1:0]        q_count;
    logic                 q_empty;
    logic                 q_push;
    logic                 q_pop;

    assign flush        = fif.redirect_valid;
    assign fetch_addr   = flush ? (fif.redirect_pc & 16'hFFFE) : pc_q;
    assign fif.mem_raddr = fetch_addr[15:1];
    assign arrive       = vld_q[MEM_LAT-1] && !flush;
    assign arr_entry    = '{pc: ipc_q[MEM_LAT-1], instr: fif.mem_rdata};

    // Credit: every issued fetch owns a queue slot until it is popped.
    always_comb begin
        occupancy = int'(q_count);
        for (int i = 0; i < MEM_LAT; i++) occupancy += int'(vld_q[i]);
        if (flush) occupancy = 0;
        issue = !fif.halt && (occupancy < DEPTH);
        pc_d  = issue ? fetch_addr + 16'd2 : fetch_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            vld_q <= '0;
            for (int i = 0; i < MEM_LAT; i++) ipc_q[i] <= '0;
        end else begin
            pc_q     <= pc_d;
            vld_q[0] <= issue;
            ipc_q[0] <= fetch_addr;
            for (int i = 1; i < MEM_LAT; i++) begin
                vld_q[i] <= vld_q[i-1] && !flush;
                ipc_q[i] <= ipc_q[i-1];
            end
        end
    end

`ifdef FETCH_BYPASS_EN
    logic bypass;
    assign bypass        = arrive && q_empty;
    assign fif.out_valid = !flush && (!q_empty || arrive);
    assign fif.out_pc    = bypass ? arr_entry.pc : head.pc;
    assign fif.out_instr = bypass ? arr_entry.instr : head.instr;
    assign q_pop         = fif.out_valid && fif.out_ready && !bypass;
    assign q_push        = arrive && !(bypass && fif.out_ready);
`else
    assign fif.out_valid = !flush && !q_empty;
    assign fif.out_pc    = head.pc;
    assign fif.out_instr = head.instr;
    assign q_pop         = fif.out_valid && fif.out_ready;
    assign q_push        = arrive;
`endif

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .din_i   (arr_entry),
        .head_o  (head),
        .count_o (q_count),
        .empty_o (q_empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a program-order model
module tb_fetch_unit;

`ifdef FETCH_BYPASS_EN
    localparam int FIRST = 2;
`else
    localparam int FIRST = 3;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_unit_if f();

    fetch_unit #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fif   (f)
    );

    // Instruction memory: word[n] = n, two-cycle read pipe.
    logic [15:0] rd1, rd2;
    always @(posedge clk) begin
        rd1 <= {1'b0, f.mem_raddr};
        rd2 <= rd1;
    end
    assign f.mem_rdata = rd2;

    function automatic logic [15:0] word_at(input logic [15:0] pc);
        return {1'b0, pc[15:1]};
    endfunction

    task automatic drive(input logic rdy, input logic hlt, input logic rv, input logic [15:0] rpc);
        @(negedge clk);
        f.out_ready      = rdy;
        f.halt           = hlt;
        f.redirect_valid = rv;
        f.redirect_pc    = rpc;
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        @(negedge clk);
        rst_n            = 1'b0;
        f.out_ready      = rdy;
        f.halt           = 1'b0;
        f.redirect_valid = 1'b0;
        f.redirect_pc    = 16'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        f.out_ready = 1'b1; f.halt = 1'b0; f.redirect_valid = 1'b0; f.redirect_pc = 16'h0;
        @(negedge clk);
        checks++;
        if (f.out_valid !== 1'b0 || f.out_pc !== 16'h0 || f.out_instr !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b pc=%h instr=%h expected 0/0000/0000", f.out_valid, f.out_pc, f.out_instr);
        end
        checks++;
        if (f.mem_raddr !== 15'h0) begin
            errors++;
            $display("FAIL reset_raddr: got %h expected 0000", f.mem_raddr);
        end
    endtask

    task automatic test_stream();
        logic [15:0] e;
        do_reset(1'b1);
        for (int k = 0; k <= FIRST + 3; k++) begin
            if (k > 0) drive(1'b1, 1'b0, 1'b0, 16'h0);
            checks++;
            if (k < FIRST) begin
                if (f.out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_latency k=%0d: valid=%b expected 0", k, f.out_valid);
                end
            end else begin
                e = 16'((k - FIRST) * 2);
                if (f.out_valid !== 1'b1 || f.out_pc !== e || f.out_instr !== word_at(e)) begin
                    errors++;
                    $display("FAIL stream k=%0d: valid=%b pc=%h instr=%h expected 1/%h/%h", k, f.out_valid, f.out_pc, f.out_instr, e, word_at(e));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int got;
        logic [15:0] e;
        do_reset(1'b0);
        repeat (20) drive(1'b0, 1'b0, 1'b0, 16'h0);
        checks++;
        if (f.out_valid !== 1'b1 || f.out_pc !== 16'h0) begin
            errors++;
            $display("FAIL bp_head: valid=%b pc=%h expected 1/0000", f.out_valid, f.out_pc);
        end
        checks++;
        if (f.mem_raddr !== 15'h4) begin
            errors++;
            $display("FAIL bp_issue_stop: raddr=%h expected 0004", f.mem_raddr);
        end
        got = 0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            drive(1'b1, 1'b0, 1'b0, 16'h0);
            if (f.out_valid === 1'b1) begin
                e = 16'(got * 2);
                checks++;
                if (f.out_pc !== e || f.out_instr !== word_at(e)) begin
                    errors++;
                    $display("FAIL bp_drain #%0d: pc=%h instr=%h expected %h/%h", got, f.out_pc, f.out_instr, e, word_at(e));
                end
                got++;
            end
        end
        checks++;
        if (got != 5) begin
            errors++;
            $display("FAIL bp_drain_count: got %0d expected 5", got);
        end
    endtask

    task automatic test_redirect();
        int got;
        logic [15:0] e;
        do_reset(1'b0);
        repeat (4) drive(1'b0, 1'b0, 1'b0, 16'h0);
        drive(1'b0, 1'b0, 1'b1, 16'h0040);
        checks++;
        if (f.out_valid !== 1'b0 || f.mem_raddr !== 15'h0020) begin
            errors++;
            $display("FAIL redir_cycle: valid=%b raddr=%h expected 0/0020", f.out_valid, f.mem_raddr);
        end
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                drive(1'b1, 1'b0, 1'b1, 16'h0041);
                checks++;
                if (f.out_valid !== 1'b0 || f.mem_raddr !== 15'h0020) begin
                    errors++;
                    $display("FAIL redir_odd_cycle: valid=%b raddr=%h expected 0/0020", f.out_valid, f.mem_raddr);
                end
            end
            got = 0;
            for (int c = 0; c < 20 && got < 2; c++) begin
                drive(1'b1, 1'b0, 1'b0, 16'h0);
                if (f.out_valid === 1'b1) begin
                    e = 16'h0040 + 16'(got * 2);
                    checks++;
                    if (f.out_pc !== e || f.out_instr !== word_at(e)) begin
                        errors++;
                        $display("FAIL redir_target p%0d #%0d: pc=%h instr=%h expected %h/%h", pass, got, f.out_pc, f.out_instr, e, word_at(e));
                    end
                    got++;
                end
            end
            checks++;
            if (got != 2) begin
                errors++;
                $display("FAIL redir_count p%0d: got %0d expected 2", pass, got);
            end
        end
    endtask

    task automatic test_wrap();
        int got;
        logic [15:0] e;
        drive(1'b1, 1'b0, 1'b1, 16'hFFFC);
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            drive(1'b1, 1'b0, 1'b0, 16'h0);
            if (f.out_valid === 1'b1) begin
                e = 16'hFFFC + 16'(got * 2);
                checks++;
                if (f.out_pc !== e || f.out_instr !== word_at(e)) begin
                    errors++;
                    $display("FAIL wrap #%0d: pc=%h instr=%h expected %h/%h", got, f.out_pc, f.out_instr, e, word_at(e));
                end
                got++;
            end
        end
        checks++;
        if (got != 4) begin
            errors++;
            $display("FAIL wrap_count: got %0d expected 4", got);
        end
    endtask

    task automatic test_halt_and_reset();
        int got;
        logic [15:0] e;
        do_reset(1'b1);
        drive(1'b1, 1'b0, 1'b0, 16'h0);
        got = 0;
        for (int c = 0; c < 12; c++) begin
            drive(1'b1, 1'b1, 1'b0, 16'h0);
            if (f.out_valid === 1'b1) begin
                e = 16'(got * 2);
                checks++;
                if (f.out_pc !== e) begin
                    errors++;
                    $display("FAIL halt_deliver #%0d: pc=%h expected %h", got, f.out_pc, e);
                end
                got++;
            end
        end
        checks++;
        if (got != 2) begin
            errors++;
            $display("FAIL halt_count: got %0d expected 2", got);
        end
        got = 0;
        for (int c = 0; c < 10 && got < 1; c++) begin
            drive(1'b1, 1'b0, 1'b0, 16'h0);
            if (f.out_valid === 1'b1) begin
                checks++;
                if (f.out_pc !== 16'h0004) begin
                    errors++;
                    $display("FAIL halt_resume: pc=%h expected 0004", f.out_pc);
                end
                got++;
            end
        end
        checks++;
        if (got != 1) begin
            errors++;
            $display("FAIL halt_resume_count: got %0d expected 1", got);
        end
        repeat (6) drive(1'b0, 1'b0, 1'b0, 16'h0);
        checks++;
        if (f.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL prereset_valid: valid=%b expected 1", f.out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (f.out_valid !== 1'b0 || f.out_pc !== 16'h0 || f.out_instr !== 16'h0 || f.mem_raddr !== 15'h0) begin
            errors++;
            $display("FAIL async_reset: valid=%b pc=%h instr=%h raddr=%h expected 0/0000/0000/0000", f.out_valid, f.out_pc, f.out_instr, f.mem_raddr);
        end
        @(negedge clk);
        f.out_ready = 1'b1;
        rst_n = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 2; c++) begin
            drive(1'b1, 1'b0, 1'b0, 16'h0);
            if (f.out_valid === 1'b1) begin
                e = 16'(got * 2);
                checks++;
                if (f.out_pc !== e) begin
                    errors++;
                    $display("FAIL restart #%0d: pc=%h expected %h", got, f.out_pc, e);
                end
                got++;
            end
        end
        checks++;
        if (got != 2) begin
            errors++;
            $display("FAIL restart_count: got %0d expected 2", got);
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_pc, rpc;
        logic rdy, hlt, rv;
        int delivered;
        do_reset(1'b0);
        exp_pc = 16'h0;
        hlt = 1'b0;
        delivered = 0;
        for (int c = 0; c < 1500; c++) begin
            rv  = ($urandom_range(0, 31) == 0);
            rpc = 16'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) hlt = !hlt;
            drive(rdy, hlt, rv, rpc);
            if (rv) begin
                checks++;
                if (f.out_valid !== 1'b0 || f.mem_raddr !== rpc[15:1]) begin
                    errors++;
                    $display("FAIL rand_redirect c=%0d: valid=%b raddr=%h expected 0/%h", c, f.out_valid, f.mem_raddr, rpc[15:1]);
                end
                exp_pc = rpc & 16'hFFFE;
            end else if (f.out_valid === 1'b1 && rdy) begin
                checks++;
                if (f.out_pc !== exp_pc || f.out_instr !== word_at(exp_pc)) begin
                    errors++;
                    $display("FAIL rand_order c=%0d: pc=%h instr=%h expected %h/%h", c, f.out_pc, f.out_instr, exp_pc, word_at(exp_pc));
                end
                exp_pc = exp_pc + 16'd2;
                delivered++;
            end
        end
        checks++;
        if (delivered < 200) begin
            errors++;
            $display("FAIL rand_progress: delivered %0d expected at least 200", delivered);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_halt_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
